mcs4_rom_ctrl: RTL and testbench

ROM-side bus controller and arbiter for the `i4004` core. It tracks the core's 8-phase instruction cycle from `sync` and assembles the 12-bit fetch address from the A1–A3 nibbles. It serves the opcode byte back as OPR/OPA nibbles in M1/M2. It also shares the single-port program memory with a host (PYNQ) load/readback port, which is granted only in non-fetch slots.

---
 rtl/mcs4_rom_ctrl.sv | 168 ++++++++++++++++
 tb/tb_mcs4_rom_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mcs4_rom_ctrl.sv
`default_nettype none
// mcs4_rom_ctrl: i4004 ROM-side phase tracker, fetch path and host/fetch memory arbiter.
// Optional fetch counter built when MCS4_ROMCTL_FETCH_CNT_EN is defined.
module mcs4_rom_ctrl #(
   parameter int AW = 12,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          sync,
   input  logic [3:0]    cpu_dout,
   output logic [3:0]    cpu_din,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_ack,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          locked,
   output logic          sync_err,
   output logic [15:0]   fetch_cnt
);

   typedef enum logic [3:0] {
      UNSYNC = 4'd0,
      A1     = 4'd1,
      A2     = 4'd2,
      A3     = 4'd3,
      M1     = 4'd4,
      M2     = 4'd5,
      X1     = 4'd6,
      X2     = 4'd7,
      X3     = 4'd8
   } phase_t;

   phase_t        state;
   logic [3:0]    addr_lo;
   logic [3:0]    addr_mid;
   logic [DW-1:0] fetch_buf;
   logic [DW-1:0] rdata_hold;
   logic          fetch_slot;
   logic          host_grant;

   function automatic phase_t next_phase(input phase_t p);
      case (p)
         A1:      return A2;
         A2:      return A3;
         A3:      return M1;
         M1:      return M2;
         M2:      return X1;
         X1:      return X2;
         X2:      return X3;
         default: return A1;
      endcase
   endfunction

   // Both grants are gated by reset so the memory port is quiet while rst_n is low.
   assign fetch_slot = rst_n && (state == A3);
   assign host_grant = rst_n && host_req && (state != A3);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= UNSYNC;
         locked    <= 1'b0;
         sync_err  <= 1'b0;
         addr_lo   <= 4'h0;
         addr_mid  <= 4'h0;
         fetch_buf <= '0;
      end else begin
         sync_err <= 1'b0;
         case (state)
            UNSYNC: begin
               if (sync) begin
                  state  <= A1;
                  locked <= 1'b1;
               end
            end
            X3: begin
               if (sync) begin
                  state <= A1;
               end else begin
                  state    <= UNSYNC;
                  locked   <= 1'b0;
                  sync_err <= 1'b1;
               end
            end
            default: begin
               // sync means the core is in X3: realign to it and drop the current fetch
               if (sync) begin
                  state    <= A1;
                  sync_err <= 1'b1;
               end else begin
                  state <= next_phase(state);
               end
            end
         endcase
         if (state == A1) addr_lo   <= cpu_dout;
         if (state == A2) addr_mid  <= cpu_dout;
         if (state == M1) fetch_buf <= mem_rdata;
      end
   end

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      host_ack  = 1'b0;
      if (fetch_slot) begin
         mem_en   = 1'b1;
         mem_addr = {cpu_dout, addr_mid, addr_lo};
      end else if (host_grant) begin
         mem_en   = 1'b1;
         mem_we   = host_we;
         mem_addr = host_addr;
         host_ack = 1'b1;
         if (host_we) mem_wdata = host_wdata;
      end
   end

   always_comb begin
      cpu_din = 4'h0;
      if (rst_n) begin
         case (state)
            M1:      cpu_din = mem_rdata[7:4];
            M2:      cpu_din = fetch_buf[3:0];
            default: cpu_din = 4'h0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         host_rvalid <= 1'b0;
         rdata_hold  <= '0;
      end else begin
         host_rvalid <= host_grant && !host_we;
         if (host_rvalid) rdata_hold <= mem_rdata;
      end
   end

   // Read data arrives from the memory in the rvalid cycle itself; hold it afterwards.
   assign host_rdata = host_rvalid ? mem_rdata : rdata_hold;

`ifdef MCS4_ROMCTL_FETCH_CNT_EN
   logic [15:0] fetch_cnt_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= 16'h0;
      end else if ((state == M2) && !sync && (fetch_cnt_q != 16'hFFFF)) begin
         fetch_cnt_q <= fetch_cnt_q + 16'h1;
      end
   end

   assign fetch_cnt = fetch_cnt_q;
`else
   assign fetch_cnt = 16'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mcs4_rom_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// Directed bench for mcs4_rom_ctrl with a synchronous program memory model.
module tb_mcs4_rom_ctrl;

`ifdef MCS4_ROMCTL_FETCH_CNT_EN
   localparam bit CNT_ON = 1'b1;
`else
   localparam bit CNT_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sync;
   logic [3:0]  cpu_dout;
   logic [3:0]  cpu_din;
   logic        mem_en;
   logic        mem_we;
   logic [11:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        host_req;
   logic        host_we;
   logic [11:0] host_addr;
   logic [7:0]  host_wdata;
   logic        host_ack;
   logic        host_rvalid;
   logic [7:0]  host_rdata;
   logic        locked;
   logic        sync_err;
   logic [15:0] fetch_cnt;

   logic [7:0]  mem [0:4095];
   int          total = 0;
   int          bad = 0;
   int          n_fetch = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   mcs4_rom_ctrl #(.AW(12), .DW(8)) dut (
      .clk(clk), .rst_n(rst_n), .sync(sync), .cpu_dout(cpu_dout), .cpu_din(cpu_din),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_ack(host_ack), .host_rvalid(host_rvalid),
      .host_rdata(host_rdata), .locked(locked), .sync_err(sync_err), .fetch_cnt(fetch_cnt)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_cnt(input int n);
      return CNT_ON ? 16'(n) : 16'h0;
   endfunction

   task automatic host_write(input logic [11:0] a, input logic [7:0] d);
      host_req = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
      cyc();
      host_req = 1'b0; host_we = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sync = 1'b1; cpu_dout = 4'h0;
      host_req = 1'b1; host_we = 1'b1; host_addr = 12'h7FF; host_wdata = 8'h55;
      cyc(); cyc(); #1;
      total++; if (cpu_din !== 4'h0) begin bad++; $display("FAIL rst_cpu_din: got %h want 0", cpu_din); end
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
      total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
      total++; if (mem_addr !== 12'h0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_addr); end
      total++; if (mem_wdata !== 8'h0) begin bad++; $display("FAIL rst_mem_wdata: got %h want 0", mem_wdata); end
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL rst_host_ack: got %b want 0", host_ack); end
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b want 0", host_rvalid); end
      total++; if (host_rdata !== 8'h0) begin bad++; $display("FAIL rst_rdata: got %h want 0", host_rdata); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %b want 0", locked); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL rst_sync_err: got %b want 0", sync_err); end
      total++; if (fetch_cnt !== 16'h0) begin bad++; $display("FAIL rst_fetch_cnt: got %h want 0", fetch_cnt); end
      rst_n = 1'b1; sync = 1'b0; host_req = 1'b0; host_we = 1'b0;
      cyc();
      host_write(12'h2A5, 8'hD7);
      host_write(12'h123, 8'h5E);
      host_write(12'h010, 8'h3C);
      host_write(12'h456, 8'h91);
   endtask

   task automatic test_lock_in();
      #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_pre: got %b want 0", locked); end
      sync = 1'b1; #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL lock_sync_cycle: got %b want 0", locked); end
      cyc();
      sync = 1'b0; #1;
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_after: got %b want 1", locked); end
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL lock_no_err: got %b want 0", sync_err); end
   endtask

   // Entered at the A1 cycle; leaves at the cycle after X3.
   task automatic run_fetch(input logic [11:0] a, input logic [7:0] d, input bit host_a3, input bit drop_sync);
      sync = 1'b0; cpu_dout = a[3:0]; #1;
      total++; if (locked !== 1'b1) begin bad++; $display("FAIL f_locked: got %b want 1", locked); end
      total++; if (cpu_din !== 4'h0) begin bad++; $display("FAIL f_a1_din: got %h want 0", cpu_din); end
      cyc();
      cpu_dout = a[7:4]; #1;
      total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL f_a2_idle: got %b want 0", mem_en); end
      cyc();
      cpu_dout = a[11:8];
      if (host_a3) begin host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010; end
      #1;
      total++; if ({mem_en, mem_we} !== 2'b10) begin bad++; $display("FAIL f_a3_en_we: got %b want 10", {mem_en, mem_we}); end
      total++; if (mem_addr !== a) begin bad++; $display("FAIL f_a3_addr: got %h want %h", mem_addr, a); end
      if (host_a3) begin
         total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL hp_a3_noack: got %b want 0", host_ack); end
      end
      cyc();
      cpu_dout = 4'h0; #1;
      total++; if (cpu_din !== d[7:4]) begin bad++; $display("FAIL f_m1_opr: got %h want %h", cpu_din, d[7:4]); end
      if (host_a3) begin
         total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL hp_m1_ack: got %b want 1", host_ack); end
         total++; if (mem_addr !== 12'h010) begin bad++; $display("FAIL hp_m1_addr: got %h want 010", mem_addr); end
      end
      cyc();
      host_req = 1'b0; #1;
      total++; if (cpu_din !== d[3:0]) begin bad++; $display("FAIL f_m2_opa: got %h want %h", cpu_din, d[3:0]); end
      if (host_a3) begin
         total++; if (host_rvalid !== 1'b1) begin bad++; $display("FAIL hp_rvalid: got %b want 1", host_rvalid); end
         total++; if (host_rdata !== 8'h3C) begin bad++; $display("FAIL hp_rdata: got %h want 3c", host_rdata); end
      end
      n_fetch++;
      cyc();
      #1;
      total++; if (fetch_cnt !== exp_cnt(n_fetch)) begin bad++; $display("FAIL f_cnt: got %0d want %0d", fetch_cnt, exp_cnt(n_fetch)); end
      total++; if (cpu_din !== 4'h0) begin bad++; $display("FAIL f_x1_din: got %h want 0", cpu_din); end
      cyc();
      cyc();
      sync = !drop_sync;
      cyc();
      sync = 1'b0;
   endtask

   task automatic test_fetch();
      run_fetch(12'h2A5, 8'hD7, 1'b0, 1'b0);
   endtask

   task automatic test_host_priority();
      run_fetch(12'h123, 8'h5E, 1'b1, 1'b0);
   endtask

   task automatic test_sync_fault();
      sync = 1'b0; cpu_dout = 4'h0;
      for (int i = 0; i < 5; i++) cyc();
      sync = 1'b1; #1;
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sf_x1_pre: got %b want 0", sync_err); end
      n_fetch++;
      cyc();
      sync = 1'b0; #1;
      total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sf_x1_err: got %b want 1", sync_err); end
      run_fetch(12'h456, 8'h91, 1'b0, 1'b0);
      run_fetch(12'h2A5, 8'hD7, 1'b0, 1'b1);
      #1;
      total++; if (sync_err !== 1'b1) begin bad++; $display("FAIL sf_x3_err: got %b want 1", sync_err); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_x3_unlock: got %b want 0", locked); end
      cyc();
      #1;
      total++; if (sync_err !== 1'b0) begin bad++; $display("FAIL sf_err_pulse: got %b want 0", sync_err); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL sf_stay_unsync: got %b want 0", locked); end
   endtask

   task automatic test_back_to_back();
      int acks = 0;
      for (int i = 0; i < 8; i++) begin
         host_req = 1'b1; host_we = 1'b1; host_addr = 12'h100 + 12'(i); host_wdata = 8'hA0 + 8'(i);
         #1;
         if (host_ack === 1'b1) acks++;
         total++; if ({mem_en, mem_we} !== 2'b11 || mem_addr !== host_addr || mem_wdata !== host_wdata) begin
            bad++; $display("FAIL b2b_wr: got en/we %b addr %h data %h want 11 %h %h", {mem_en, mem_we}, mem_addr, mem_wdata, host_addr, host_wdata);
         end
         cyc();
      end
      host_req = 1'b0; host_we = 1'b0; #1;
      total++; if (acks != 8) begin bad++; $display("FAIL b2b_acks: got %0d want 8", acks); end
      total++; if (host_ack !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %b want 0", host_ack); end
      for (int i = 0; i <= 8; i++) begin
         if (i < 8) begin host_req = 1'b1; host_we = 1'b0; host_addr = 12'h100 + 12'(i); end
         else host_req = 1'b0;
         #1;
         if (i < 8) begin
            total++; if (host_ack !== 1'b1) begin bad++; $display("FAIL b2b_rd_ack%0d: got %b want 1", i, host_ack); end
         end
         if (i > 0) begin
            total++; if (host_rvalid !== 1'b1 || host_rdata !== 8'hA0 + 8'(i - 1)) begin
               bad++; $display("FAIL b2b_rd%0d: got v=%b d=%h want v=1 d=%h", i - 1, host_rvalid, host_rdata, 8'hA0 + 8'(i - 1));
            end
         end
         cyc();
      end
      #1;
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL b2b_rv_end: got %b want 0", host_rvalid); end
   endtask

   task automatic test_reset_mid();
      sync = 1'b1; cyc();
      sync = 1'b0; cpu_dout = 4'h5; cyc();
      cpu_dout = 4'hA; cyc();
      cpu_dout = 4'h2; cyc();
      rst_n = 1'b0; host_req = 1'b1; host_we = 1'b0; host_addr = 12'h010; cpu_dout = 4'h0; #1;
      total++; if (host_ack !== 1'b0 || mem_en !== 1'b0) begin bad++; $display("FAIL rm_ack: got ack=%b en=%b want 0 0", host_ack, mem_en); end
      total++; if (cpu_din !== 4'h0) begin bad++; $display("FAIL rm_din: got %h want 0", cpu_din); end
      cyc();
      host_req = 1'b0; #1;
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid: got %b want 0", host_rvalid); end
      total++; if (fetch_cnt !== 16'h0) begin bad++; $display("FAIL rm_cnt: got %h want 0", fetch_cnt); end
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rm_locked: got %b want 0", locked); end
      rst_n = 1'b1; cyc(); #1;
      total++; if (host_rvalid !== 1'b0) begin bad++; $display("FAIL rm_rvalid_post: got %b want 0", host_rvalid); end
      cyc(); #1;
      total++; if (locked !== 1'b0) begin bad++; $display("FAIL rm_needs_sync: got %b want 0", locked); end
   endtask

   initial begin
      rst_n = 1'b0; sync = 1'b0; cpu_dout = 4'h0;
      host_req = 1'b0; host_we = 1'b0; host_addr = 12'h0; host_wdata = 8'h0;
      test_reset();
      test_lock_in();
      test_fetch();
      test_host_priority();
      test_sync_fault();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
